branch_sequencer: RTL and testbench

//  Instruction sequencer for the 8-bit core: owns the PC, fetches instruction bytes over a req/ack port,

---
 rtl/branch_sequencer_if.sv | 18 +
 rtl/branch_sequencer.sv | 91 +++++++++
 tb/tb_branch_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: imem fetch (req/ack) and execute issue (valid/ready) handshakes
interface branch_sequencer_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       exec_valid;
    logic [7:0] exec_instr;
    logic       exec_ready;
    modport master (
        output imem_req, imem_addr, exec_valid, exec_instr,
        input  imem_ack, imem_data, exec_ready
    );
    modport slave (
        input  imem_req, imem_addr, exec_valid, exec_instr,
        output imem_ack, imem_data, exec_ready
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: PC owner, fetch/decode/issue FSM with R3 branch conditions; optional BRANCH_LINK_EN adds a link register
module branch_sequencer #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [1:0] BR_OPCODE = 2'b11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [7:0]         i_r0,
    input  logic [7:0]         i_r3,
    output logic [7:0]         o_pc,
    output logic               o_br_taken,
    output logic [7:0]         o_link,
    branch_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE} state_t;
    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic       r_br_taken;
    logic       w_is_br;
    logic       w_neg;
    logic       w_zero;
    logic       w_base;
    logic       w_taken;
    logic       w_br_go;
    logic       w_retire;
    assign w_is_br  = r_ir[7:6] == BR_OPCODE;
    assign w_neg    = i_r3[7];
    assign w_zero   = i_r3 == 8'h00;
    assign w_br_go  = (r_state == S_DECODE) && w_is_br && w_taken;
    assign w_retire = ((r_state == S_DECODE) && w_is_br) || ((r_state == S_ISSUE) && bus.exec_ready);
    // condition table: cond[2] inverts the never/Z/N/N|Z base test
    always_comb begin
        w_base  = ir_bit(1) ? (ir_bit(0) ? (w_neg | w_zero) : w_neg) : (ir_bit(0) ? w_zero : 1'b0);
        w_taken = w_base ^ r_ir[2];
    end
    function automatic logic ir_bit(input int i);
        return r_ir[i];
    endfunction
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    // next-state logic; a retiring instruction parks in IDLE when run is low
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_run ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = bus.imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_is_br ? (i_run ? S_FETCH : S_IDLE) : S_ISSUE;
            S_ISSUE:  w_next = bus.exec_ready ? (i_run ? S_FETCH : S_IDLE) : S_ISSUE;
            default:  w_next = S_IDLE;
        endcase
    end
    // Moore outputs: request/valid follow the state, address/instruction are registers
    always_comb begin
        bus.imem_req   = r_state == S_FETCH;
        bus.imem_addr  = r_pc;
        bus.exec_valid = r_state == S_ISSUE;
        bus.exec_instr = r_ir;
    end
    // datapath: instruction capture, PC update on retire, taken-branch pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 8'h00;
            r_br_taken <= 1'b0;
        end else begin
            if (r_state == S_FETCH && bus.imem_ack) r_ir <= bus.imem_data;
            if (w_br_go)       r_pc <= i_r0;
            else if (w_retire) r_pc <= r_pc + 8'd1;
            r_br_taken <= w_br_go;
        end
    end
    assign o_pc       = r_pc;
    assign o_br_taken = r_br_taken;
`ifdef BRANCH_LINK_EN
    logic [7:0] r_link;
    // branch-and-link saves the return address only when the branch is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_link <= 8'h00;
        else if (w_br_go && r_ir[5]) r_link <= r_pc + 8'd1;
    end
    assign o_link = r_link;
`else
    assign o_link = 8'h00;
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: randomized instruction stream against an instruction-level PC/branch/link model
module tb_branch_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] r0;
    logic [7:0] r3;
    logic [7:0] pc;
    logic       br_taken;
    logic [7:0] link;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_link = 8'h00;
    logic [7:0] r3_set [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    branch_sequencer_if bus();
    branch_sequencer dut (
        .clk(clk), .reset(reset), .i_run(run), .i_r0(r0), .i_r3(r3),
        .o_pc(pc), .o_br_taken(br_taken), .o_link(link), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic bit ref_taken(input logic [2:0] c, input logic [7:0] r);
        int v;
        v = int'($signed(r));
        case (c)
            3'd0: return 1'b0;
            3'd1: return v == 0;
            3'd2: return v < 0;
            3'd3: return v <= 0;
            3'd4: return 1'b1;
            3'd5: return v != 0;
            3'd6: return v >= 0;
            default: return v > 0;
        endcase
    endfunction
    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", bus.imem_req, 1);
    endtask
    task automatic do_instr(input logic [7:0] ins, input logic [7:0] r0v, input logic [7:0] r3v,
                            input int ack_d, input int rdy_d, input bit drop);
        bit br;
        bit tk;
        wait_req();
        chk("imem_addr", bus.imem_addr, m_pc);
        r0 = r0v;
        r3 = r3v;
        repeat (ack_d) begin
            @(negedge clk);
            chk("req_hold", {bus.imem_req, bus.imem_addr}, {1'b1, m_pc});
            chk("fetch_no_valid", bus.exec_valid, 0);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = ins;
        if (drop) run = 1'b0;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'($urandom);
        @(negedge clk);
        br = ins[7:6] == 2'b11;
        tk = br && ref_taken(ins[2:0], r3v);
        if (br) begin
            if (tk) begin
`ifdef BRANCH_LINK_EN
                if (ins[5]) m_link = m_pc + 8'd1;
`endif
                m_pc = r0v;
            end else m_pc = m_pc + 8'd1;
            chk("br_taken", br_taken, tk);
            chk("pc_br", pc, m_pc);
            chk("br_no_valid", bus.exec_valid, 0);
            @(negedge clk);
            chk("br_pulse_end", br_taken, 0);
        end else begin
            chk("exec_valid", bus.exec_valid, 1);
            chk("exec_instr", bus.exec_instr, ins);
            chk("nb_no_pulse", br_taken, 0);
            repeat (rdy_d) begin
                bus.imem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("exec_hold", {bus.exec_valid, bus.exec_instr}, {1'b1, ins});
                chk("pc_stall", pc, m_pc);
            end
            bus.imem_ack   = 1'b0;
            bus.exec_ready = 1'b1;
            @(negedge clk);
            bus.exec_ready = 1'b0;
            m_pc = m_pc + 8'd1;
            chk("pc_nb", pc, m_pc);
            chk("exec_done", bus.exec_valid, 0);
        end
        chk("link", link, m_link);
        if (drop) begin
            repeat (3) begin
                @(negedge clk);
                chk("idle_req", bus.imem_req, 0);
                chk("idle_pc", pc, m_pc);
            end
            run = 1'b1;
        end
    endtask
    initial begin
        reset = 1'b1;
        run = 1'b0;
        r0 = 8'h00;
        r3 = 8'h00;
        bus.imem_ack = 1'b0;
        bus.imem_data = 8'h00;
        bus.exec_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", bus.exec_valid, 0);
        chk("rst_br", br_taken, 0);
        chk("rst_link", link, 8'h00);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_norun", bus.imem_req, 0);
        end
        run = 1'b1;
        do_instr(8'h05, 8'h00, 8'h00, 2, 0, 0);
        do_instr(8'hC1, 8'h40, 8'h00, 1, 0, 0);
        do_instr(8'hC1, 8'h40, 8'h01, 0, 0, 0);
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 5; k++)
                do_instr({5'b11000, 3'(c)}, 8'($urandom), r3_set[k], 0, 0, 0);
        do_instr(8'hC4, 8'hFF, 8'h00, 1, 0, 0);
        do_instr(8'h12, 8'h00, 8'h00, 0, 1, 0);
        do_instr(8'hC4, m_pc, 8'h00, 0, 0, 0);
        do_instr(8'hC4, m_pc, 8'h00, 2, 0, 0);
        do_instr(8'h33, 8'h00, 8'h00, 0, 5, 1);
        wait_req();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_req", bus.imem_req, 0);
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_link", link, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        m_pc = 8'h00;
        m_link = 8'h00;
        do_instr(8'hC4, 8'h10, 8'h00, 0, 0, 0);
        do_instr(8'hE4, 8'h80, 8'h00, 0, 0, 0);
        do_instr(8'hE1, 8'h20, 8'h05, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ins;
            logic [7:0] rv;
            ins = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ins[7:6] = 2'b11;
            rv = ($urandom_range(0, 1) == 1) ? r3_set[$urandom_range(0, 4)] : 8'($urandom);
            do_instr(ins, 8'($urandom), rv, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 9) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
